// File: rtl/cache_miss_controller.sv
// Sequencing FSM for a 2-way set-associative L1 cache: hit service, dirty-victim writeback,
// line fill with a retry lookup, plus saturating hit/miss/writeback counters.
module cache_miss_controller #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 hit,
   input  logic                 replace,
   input  logic                 dirty,
   input  logic                 update_way,
   input  logic                 hit_way,
   input  logic                 pmem_resp,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 way_sel,
   output logic                 addr_sel,
   output logic                 data_sel,
   output logic                 load_data,
   output logic                 load_tag,
   output logic                 set_valid,
   output logic                 set_dirty,
   output logic                 clr_dirty,
   output logic                 load_lru,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   localparam logic [1:0] S_COMPARE   = 2'd0;
   localparam logic [1:0] S_WRITEBACK = 2'd1;
   localparam logic [1:0] S_FILL      = 2'd2;

   logic [1:0] state;
   logic [1:0] next_state;
   logic       victim_way;
   logic       retry;
   logic       req;
   logic       hit_inc;
   logic       miss_inc;
   logic       wb_inc;

   assign req = mem_read | mem_write;

   // Outputs are forced low while rst is high so no pmem request or array load escapes the reset cycle.
   always_comb begin
      next_state = state;
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      way_sel    = 1'b0;
      addr_sel   = 1'b0;
      data_sel   = 1'b0;
      load_data  = 1'b0;
      load_tag   = 1'b0;
      set_valid  = 1'b0;
      set_dirty  = 1'b0;
      clr_dirty  = 1'b0;
      load_lru   = 1'b0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      wb_inc     = 1'b0;
      if (!rst) begin
         case (state)
            S_COMPARE: begin
               if (req) begin
                  if (hit) begin
                     mem_resp = 1'b1;
                     way_sel  = hit_way;
                     load_lru = 1'b1;
                     hit_inc  = ~retry;
                     if (mem_write) begin
                        load_data = 1'b1;
                        set_dirty = 1'b1;
                     end
                  end else begin
                     miss_inc = 1'b1;
                     if (replace && dirty) begin
                        wb_inc     = 1'b1;
                        next_state = S_WRITEBACK;
                     end else begin
                        next_state = S_FILL;
                     end
                  end
               end
            end
            S_WRITEBACK: begin
               pmem_write = 1'b1;
               addr_sel   = 1'b1;
               way_sel    = victim_way;
               if (pmem_resp) next_state = S_FILL;
            end
            S_FILL: begin
               pmem_read = 1'b1;
               way_sel   = victim_way;
               if (pmem_resp) begin
                  load_data  = 1'b1;
                  data_sel   = 1'b1;
                  load_tag   = 1'b1;
                  set_valid  = 1'b1;
                  clr_dirty  = 1'b1;
                  next_state = S_COMPARE;
               end
            end
            default: next_state = S_COMPARE;
         endcase
      end
   end

   // retry lives for exactly the one COMPARE cycle after a fill so that lookup is not counted as a hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_COMPARE;
         victim_way <= 1'b0;
         retry      <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         state <= next_state;
         if (state == S_COMPARE) begin
            retry <= 1'b0;
            if (req && !hit) victim_way <= update_way;
         end
         if (state == S_FILL && pmem_resp) retry <= 1'b1;
         if (hit_inc && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
         if (miss_inc && miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
         if (wb_inc && wb_count != '1) wb_count <= wb_count + CNT_WIDTH'(1);
      end
   end

endmodule
